// File: rtl/ram_dual_port_if.sv
// Bus bundle for the dual-port scratch RAM: one write port, one read port,
// plus the post-reset clear status flag.
interface ram_dual_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  we;
  logic                  init_busy;

  modport master (
    output data, read_addr, write_addr, we,
    input  q, init_busy
  );

  modport slave (
    input  data, read_addr, write_addr, we,
    output q, init_busy
  );
endinterface

// File: rtl/ram_dual_port.sv
// Simple dual-port synchronous RAM (one write port, one read port, one clock).
// After every reset a sequencer walks the whole array writing zeros, so the
// contents are deterministic before the first user access.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | clearing mem[ptr] each cycle; user writes ignored, q held at 0
// READY | normal operation: read-first registered read, enabled write
module ram_dual_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst,
  ram_dual_port_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic                  busy_q;
  logic                  next_busy;
  logic [DATA_WIDTH-1:0] q_q;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State, clear pointer and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= next_state;
      ptr    <= next_ptr;
      busy_q <= next_busy;
    end
  end

  // Next-state logic and write-port steering (clear sequencer vs. user port).
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_busy  = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.write_addr;
    mem_wdata  = bus.data;
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        next_ptr  = ptr + PTR_ONE;
        if (ptr == PTR_LAST) begin
          next_state = READY;
          next_busy  = 1'b0;
        end
      end
      READY: begin
        mem_we = bus.we;
      end
      default: begin
        next_state = INIT;
      end
    endcase
    // Contents are left alone during the reset cycle itself.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read: old contents win on a same-address collision because
  // the array update above is non-blocking.
  always_ff @(posedge clk) begin
    if (rst || state == INIT) begin
      q_q <= '0;
    end else begin
      q_q <= mem[bus.read_addr];
    end
  end

  assign bus.q         = q_q;
  assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_ram_dual_port.sv
// Directed plus randomized bench for ram_dual_port against a behavioural
// model: an array of words, a count of remaining clear cycles, and the
// read-before-write rule.
module tb_ram_dual_port;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk;
  logic rst;

  ram_dual_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_dual_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            clear_left;
  logic [DW-1:0] m_q;
  logic          m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then
  // compare q and init_busy just after the edge.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] d, input logic [AW-1:0] ra);
    rst            = r;
    bus.we         = w;
    bus.write_addr = wa;
    bus.data       = d;
    bus.read_addr  = ra;
    @(posedge clk);
    if (r) begin
      clear_left = DEPTH;
      m_busy     = 1'b1;
      m_q        = '0;
    end else if (clear_left > 0) begin
      clear_left--;
      m_q = '0;
      if (clear_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy = 1'b0;
      end
    end else begin
      m_q = m_mem[ra];
      if (w) m_mem[wa] = d;
    end
    #1;
    chk("q_model", 32'(bus.q), 32'(m_q));
    chk("busy_model", 32'(bus.init_busy), 32'(m_busy));
  endtask

  initial begin
    int n;
    foreach (m_mem[i]) m_mem[i] = '0;
    clear_left = 0;
    m_busy     = 1'b0;
    m_q        = '0;
    rst            = 1'b0;
    bus.we         = 1'b0;
    bus.write_addr = '0;
    bus.data       = '0;
    bus.read_addr  = '0;
    @(negedge clk);

    // Reset for two cycles.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_q", 32'(bus.q), 32'h0);
    chk("reset_busy", 32'(bus.init_busy), 32'h1);

    // Count busy cycles; a write attempt to address 3 lands mid-clear.
    n = 0;
    do begin
      if (n == 5) cyc(0, 1, 6'd3, 8'h55, 6'd3);
      else        cyc(0, 0, 0, 0, 6'd3);
      n++;
    end while (bus.init_busy === 1'b1 && n < 200);
    chk("init_len", 32'(n), 32'd64);

    cyc(0, 0, 0, 0, 6'd16);
    chk("rd16_after_init", 32'(bus.q), 32'h00);

    // Basic write/read.
    cyc(0, 1, 6'd5, 8'hAA, 6'd0);
    cyc(0, 1, 6'd10, 8'hB3, 6'd0);
    cyc(0, 0, 0, 0, 6'd16);
    chk("rd16", 32'(bus.q), 32'h00);
    cyc(0, 0, 0, 0, 6'd10);
    chk("rd10", 32'(bus.q), 32'hB3);

    // Read-during-write on the same address returns old data.
    cyc(0, 1, 6'd5, 8'hF0, 6'd5);
    chk("rdw_old", 32'(bus.q), 32'hAA);
    cyc(0, 0, 0, 0, 6'd5);
    chk("rdw_new", 32'(bus.q), 32'hF0);

    // Write during init had no effect.
    cyc(0, 0, 0, 0, 6'd3);
    chk("init_write_ignored", 32'(bus.q), 32'h00);

    // Independent simultaneous access.
    cyc(0, 1, 6'd0, 8'h12, 6'd10);
    chk("indep_rd10", 32'(bus.q), 32'hB3);
    cyc(0, 0, 0, 0, 6'd0);
    chk("indep_rd0", 32'(bus.q), 32'h12);

    // Mid-operation reset, with random traffic during the clear.
    cyc(0, 1, 6'd63, 8'h7E, 6'd0);
    cyc(0, 0, 0, 0, 6'd63);
    chk("rd63_before_rst", 32'(bus.q), 32'h7E);
    cyc(1, 0, 0, 0, 6'd63);
    chk("mid_rst_busy", 32'(bus.init_busy), 32'h1);
    n = 0;
    do begin
      cyc(0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 6'($urandom));
      n++;
    end while (bus.init_busy === 1'b1 && n < 200);
    chk("reinit_len", 32'(n), 32'd64);
    cyc(0, 0, 0, 0, 6'd63);
    chk("rd63_after_reinit", 32'(bus.q), 32'h00);

    // Randomized traffic, biased towards collisions on a few addresses.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom);
      cyc(0, 1'($urandom_range(0, 1)), wa, 8'($urandom), ra);
    end

    // Short reset mid-init followed by a full clear.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 6'($urandom), 8'($urandom), 6'($urandom));
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) cyc(0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 6'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
